mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/rr_arbiter2.sv | 10 +
 rtl/mem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, write-size codes and address limit shared by mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, RESP} state_t;
    typedef enum logic [1:0] {NONE, BYTE, HALF, WORD} wsize_t;
    localparam logic [31:0] MEM_LIMIT_DEFAULT = 32'h0002_0000;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; on contention the port not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       id,
    output logic       valid
);
    assign id    = (&req) ? ~last : req[1];
    assign valid = |req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory, one transaction at a time.
// Define MEM_ARBITER_TIMEOUT_EN to abort writes that see no memory response within 255 cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] MEM_LIMIT = WORD_SIZE'(MEM_LIMIT_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_0,
    input  logic [1:0]           we_0,
    input  logic [WORD_SIZE-1:0] addr_0,
    input  logic [WORD_SIZE-1:0] wdata_0,
    output logic                 gnt_0,
    output logic                 ack_0,
    output logic                 err_0,
    output logic [WORD_SIZE-1:0] rdata_0,
    input  logic                 req_1,
    input  logic [1:0]           we_1,
    input  logic [WORD_SIZE-1:0] addr_1,
    input  logic [WORD_SIZE-1:0] wdata_1,
    output logic                 gnt_1,
    output logic                 ack_1,
    output logic                 err_1,
    output logic [WORD_SIZE-1:0] rdata_1,
    output logic [31:0]          mem_address,
    output logic [1:0]           mem_write_mode,
    output logic [7:0]           mem_write_byte,
    output logic [15:0]          mem_write_half_word,
    output logic [31:0]          mem_write_word,
    input  logic [31:0]          mem_word_output,
    input  logic                 mem_done,
    input  logic                 mem_error
);
    state_t               r_state, w_next;
    logic [WORD_SIZE-1:0] r_addr, r_wdata, r_rdata_0, r_rdata_1;
    logic [WORD_SIZE-1:0] w_addr_in, w_wdata_in;
    logic [1:0]           r_we, w_we_in;
    logic                 r_id, r_last, r_err, r_pend;
    logic                 w_id, w_valid, w_grant, w_oob, w_resp, w_tmo;

    rr_arbiter2 u_rr (.req({req_1, req_0}), .last(r_last), .id(w_id), .valid(w_valid));

    // r_pend holds the one IDLE cycle an out-of-range request spends before its error response
    assign w_grant    = rst && r_state == IDLE && !r_pend && w_valid;
    assign w_addr_in  = w_id ? addr_1 : addr_0;
    assign w_wdata_in = w_id ? wdata_1 : wdata_0;
    assign w_we_in    = w_id ? we_1 : we_0;
    assign w_oob      = w_addr_in >= MEM_LIMIT;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = r_pend ? RESP : (w_grant && !w_oob) ? (w_we_in == NONE ? RD1 : WR) : IDLE;
            RD1:     w_next = RD2;
            RD2:     w_next = RESP;
            WR:      w_next = (mem_done || mem_error || w_tmo) ? RESP : WR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= NONE;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
            r_err     <= 1'b0;
            r_pend    <= 1'b0;
            r_rdata_0 <= '0;
            r_rdata_1 <= '0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_grant && w_oob;
            if (w_grant) begin
                r_addr  <= w_addr_in;
                r_wdata <= w_wdata_in;
                r_we    <= w_we_in;
                r_id    <= w_id;
                r_last  <= w_id;
                r_err   <= w_oob;
            end
            if (r_state == WR) r_err <= mem_error || (w_tmo && !mem_done);
            if (r_state == RD2 && !r_id) r_rdata_0 <= WORD_SIZE'(mem_word_output);
            if (r_state == RD2 && r_id) r_rdata_1 <= WORD_SIZE'(mem_word_output);
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    // counts WR cycles starting at 1, so reaching 255 means 255 cycles without a response
    logic [7:0] r_tmo;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tmo <= '0;
        else r_tmo <= (r_state == WR) ? r_tmo + 8'd1 : 8'd1;
    end
    assign w_tmo = r_tmo == 8'hFF;
`else
    assign w_tmo = 1'b0;
`endif

    assign w_resp              = r_state == RESP;
    assign gnt_0               = w_grant && !w_id;
    assign gnt_1               = w_grant && w_id;
    assign ack_0               = w_resp && !r_id;
    assign ack_1               = w_resp && r_id;
    assign err_0               = ack_0 && r_err;
    assign err_1               = ack_1 && r_err;
    assign rdata_0             = r_rdata_0;
    assign rdata_1             = r_rdata_1;
    assign mem_address         = 32'(r_addr);
    assign mem_write_mode      = (r_state == WR) ? r_we : NONE;
    assign mem_write_byte      = r_wdata[7:0];
    assign mem_write_half_word = r_wdata[15:0];
    assign mem_write_word      = 32'(r_wdata);
endmodule
